ps2_rx_keydecode: RTL and testbench

//   PS/2 keyboard front end: receives one 11-bit device-to-host PS/2 frame and

---
 rtl/ps2_rx_keydecode.sv | 107 ++++++++++
 tb/tb_ps2_rx_keydecode.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/ps2_rx_keydecode.sv
// PS/2 device-to-host frame receiver with combinational scancode-to-hex decode.
module ps2_rx_keydecode #(
    parameter int unsigned TIMEOUT_CYCLES = 50000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       PS2_clk,
    input  logic       PS2_dat,
    output logic [7:0] out,
    output logic       R_O,
    output logic       ERROR,
    output logic [3:0] key,
    output logic [1:0] flags
);

    localparam int unsigned FRAME_BITS = 11;
    localparam int unsigned CNT_W      = 4;
    localparam int unsigned TO_W       = $clog2(TIMEOUT_CYCLES + 1);

    logic [1:0]            clk_sync;
    logic                  clk_prev;
    logic [1:0]            dat_sync;
    logic [CNT_W-1:0]      bit_cnt;
    logic [FRAME_BITS-1:0] shreg;
    logic [TO_W-1:0]       to_cnt;
    logic                  fall_c;
    logic                  frame_done_c;
    logic                  timeout_c;

    assign fall_c       = clk_prev & ~clk_sync[1];
    assign frame_done_c = (bit_cnt == CNT_W'(FRAME_BITS));
    assign timeout_c    = (to_cnt >= TO_W'(TIMEOUT_CYCLES - 1));

    // Two-flop synchronisers plus a delayed clock copy for edge detection; preset to idle-high.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            clk_sync <= 2'b11;
            clk_prev <= 1'b1;
            dat_sync <= 2'b11;
        end else begin
            clk_sync <= {clk_sync[0], PS2_clk};
            clk_prev <= clk_sync[1];
            dat_sync <= {dat_sync[0], PS2_dat};
        end
    end

    // Shift bits in on PS/2 clock falling edges, publish the frame, abandon stalled frames.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt <= '0;
            shreg   <= '0;
            to_cnt  <= '0;
            out     <= 8'h00;
            R_O     <= 1'b0;
            ERROR   <= 1'b0;
        end else if (frame_done_c) begin
            // shreg[0]=start, shreg[8:1]=D0..D7, shreg[9]=parity, shreg[10]=stop
            out     <= shreg[8:1];
            ERROR   <= shreg[0] | ~shreg[10] | ~(^shreg[9:1]);
            R_O     <= 1'b1;
            bit_cnt <= '0;
            to_cnt  <= '0;
        end else begin
            R_O <= 1'b0;
            if (fall_c) begin
                shreg   <= {dat_sync[1], shreg[FRAME_BITS-1:1]};
                bit_cnt <= bit_cnt + CNT_W'(1);
                to_cnt  <= '0;
            end else if (bit_cnt != '0) begin
                if (timeout_c) begin
                    bit_cnt <= '0;
                    to_cnt  <= '0;
                end else begin
                    to_cnt <= to_cnt + TO_W'(1);
                end
            end
        end
    end

    // Scancode to hex digit / class decode, zero latency from out.
    always_comb begin
        key   = 4'h0;
        flags = 2'b00;
        case (out)
            8'h45: key = 4'h0;
            8'h16: key = 4'h1;
            8'h1E: key = 4'h2;
            8'h26: key = 4'h3;
            8'h25: key = 4'h4;
            8'h2E: key = 4'h5;
            8'h36: key = 4'h6;
            8'h3D: key = 4'h7;
            8'h3E: key = 4'h8;
            8'h46: key = 4'h9;
            8'h1C: key = 4'hA;
            8'h32: key = 4'hB;
            8'h21: key = 4'hC;
            8'h23: key = 4'hD;
            8'h24: key = 4'hE;
            8'h2B: key = 4'hF;
            8'h5A: flags = 2'b01;
            8'h66: flags = 2'b10;
            default: flags = 2'b11;
        endcase
    end

endmodule

// File: tb/tb_ps2_rx_keydecode.sv
// Directed and randomized frames against a scancode-level reference model.
module tb_ps2_rx_keydecode;

    localparam int unsigned TO = 200;
    localparam int unsigned HP = 5;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] out;
    logic       R_O;
    logic       ERROR;
    logic [3:0] key;
    logic [1:0] flags;

    int checks = 0;
    int errors = 0;
    int hi_cnt = 0;

    logic [7:0] q_out[$];
    logic       q_err[$];
    logic [3:0] q_key[$];
    logic [1:0] q_flg[$];

    logic [7:0] hex_codes [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                   8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

    ps2_rx_keydecode #(.TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .rst_n(rst_n), .PS2_clk(ps2_clk), .PS2_dat(ps2_dat),
        .out(out), .R_O(R_O), .ERROR(ERROR), .key(key), .flags(flags)
    );

    always #5 clk = ~clk;

    // Record every cycle that R_O is high together with the outputs of that cycle.
    always @(negedge clk) begin
        if (R_O === 1'b1) begin
            hi_cnt++;
            q_out.push_back(out);
            q_err.push_back(ERROR);
            q_key.push_back(key);
            q_flg.push_back(flags);
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference decode: {flags, key}
    function automatic logic [5:0] ref_decode(input logic [7:0] b);
        for (int i = 0; i < 16; i++)
            if (hex_codes[i] == b) return {2'b00, 4'(i)};
        if (b == 8'h5A) return {2'b01, 4'h0};
        if (b == 8'h66) return {2'b10, 4'h0};
        return {2'b11, 4'h0};
    endfunction

    // Build wire-order frame: index 0 is sent first.
    function automatic logic [10:0] make_frame(input logic [7:0] b, input bit bad_par,
                                               input bit bad_stop, input bit bad_start);
        int ones = 0;
        logic par;
        for (int i = 0; i < 8; i++) ones += int'(b[i]);
        par = (ones % 2 == 0) ? 1'b1 : 1'b0;
        return {~bad_stop ? 1'b1 : 1'b0, par ^ bad_par, b, bad_start ? 1'b1 : 1'b0};
    endfunction

    task automatic send_bits(input logic [10:0] f, input int nbits, input int gap_at,
                             input int gap_len);
        for (int i = 0; i < nbits; i++) begin
            if (i == gap_at) repeat (gap_len) @(negedge clk);
            ps2_dat = f[i];
            repeat (HP) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HP) @(negedge clk);
            ps2_clk = 1'b1;
        end
        repeat (HP) @(negedge clk);
        ps2_dat = 1'b1;
    endtask

    task automatic expect_rx(input string tag, input logic [7:0] b, input logic err);
        logic [5:0] r;
        r = ref_decode(b);
        check({tag, "_avail"}, 32'(q_out.size() > 0), 32'd1);
        if (q_out.size() > 0) begin
            check({tag, "_out"},   32'(q_out.pop_front()), 32'(b));
            check({tag, "_err"},   32'(q_err.pop_front()), 32'(err));
            check({tag, "_key"},   32'(q_key.pop_front()), 32'(r[3:0]));
            check({tag, "_flags"}, 32'(q_flg.pop_front()), 32'(r[5:4]));
        end
    endtask

    task automatic frame_test(input string tag, input logic [7:0] b, input bit bp,
                              input bit bs, input bit bst);
        int base;
        base = hi_cnt;
        send_bits(make_frame(b, bp, bs, bst), 11, 99, 0);
        repeat (10) @(negedge clk);
        check({tag, "_pulses"}, 32'(hi_cnt - base), 32'd1);
        expect_rx(tag, b, bp | bs | bst);
    endtask

    initial begin
        int base;
        logic [7:0] rb;
        int kind;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_out", 32'(out), 32'h00);
        check("rst_ro", 32'(R_O), 32'd0);
        check("rst_err", 32'(ERROR), 32'd0);
        check("rst_key", 32'(key), 32'd0);
        check("rst_flags", 32'(flags), 32'd3);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        frame_test("t1_1C", 8'h1C, 0, 0, 0);
        frame_test("t2_45badpar", 8'h45, 1, 0, 0);

        // Back-to-back F0, 16 with no idle gap
        base = hi_cnt;
        send_bits(make_frame(8'hF0, 0, 0, 0), 11, 99, 0);
        send_bits(make_frame(8'h16, 0, 0, 0), 11, 99, 0);
        repeat (10) @(negedge clk);
        check("t3_pulses", 32'(hi_cnt - base), 32'd2);
        expect_rx("t3_F0", 8'hF0, 1'b0);
        expect_rx("t3_16", 8'h16, 1'b0);

        // Partial frame abandoned after the timeout
        base = hi_cnt;
        send_bits(make_frame(8'h3D, 0, 0, 0), 5, 99, 0);
        repeat (TO + 100) @(negedge clk);
        check("t4_no_pulse", 32'(hi_cnt - base), 32'd0);
        frame_test("t4_66", 8'h66, 0, 0, 0);

        // Mid-frame stall shorter than the timeout keeps the frame
        base = hi_cnt;
        send_bits(make_frame(8'h2B, 0, 0, 0), 11, 6, TO - 60);
        repeat (10) @(negedge clk);
        check("gap_pulses", 32'(hi_cnt - base), 32'd1);
        expect_rx("gap_2B", 8'h2B, 1'b0);

        // Reset asserted mid-frame
        base = hi_cnt;
        send_bits(make_frame(8'h24, 0, 0, 0), 6, 99, 0);
        rst_n = 1'b0;
        #1;
        check("t5_out", 32'(out), 32'h00);
        check("t5_ro", 32'(R_O), 32'd0);
        check("t5_err", 32'(ERROR), 32'd0);
        check("t5_flags", 32'(flags), 32'd3);
        repeat (4) @(negedge clk);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        check("t5_no_pulse", 32'(hi_cnt - base), 32'd0);
        frame_test("t5_5A", 8'h5A, 0, 0, 0);

        frame_test("t6_3E_badstop", 8'h3E, 0, 1, 0);
        frame_test("badstart_32", 8'h32, 0, 0, 1);

        // Randomized scancodes and error injection
        for (int n = 0; n < 24; n++) begin
            kind = int'($urandom_range(0, 5));
            if ($urandom_range(0, 1) == 0) rb = hex_codes[$urandom_range(0, 15)];
            else rb = 8'($urandom());
            frame_test($sformatf("rnd%0d", n), rb, kind == 0, kind == 1, kind == 2);
        end

        check("idle_ro", 32'(R_O), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
